// File: rtl/elevator_pkg.sv
// Shared elevator constants, status codes and helpers.
// Used by the request buffer and the FSM wrapper.
package elevator_pkg;

  localparam int NUM_FLOORS      = 8;
  localparam int FLOOR_W         = 3;
  localparam int DEBOUNCE_CYCLES = 4;

  typedef logic [NUM_FLOORS-1:0] flr_vec_t;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_UP    = 4'd1,
    ST_DOWN  = 4'd2,
    ST_OPEN  = 4'd3,
    ST_CLOSE = 4'd4
  } status_e;

  // One-hot of floor f; all-zero when f is not a served floor.
  function automatic flr_vec_t floor_mask(
    input logic [FLOOR_W-1:0] f
  );
    floor_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++)
      floor_mask[i] = (f == FLOOR_W'(i));
  endfunction

endpackage

// File: rtl/request_buffer_if.sv
// Button inputs, FSM feedback and pending-request outputs
// of the request buffer.
interface request_buffer_if;
  import elevator_pkg::*;

  flr_vec_t             upcall_input;
  flr_vec_t             downcall_input;
  flr_vec_t             floor_btn_input;
  logic [FLOOR_W-1:0]   floor;
  logic [3:0]           status;
  logic                 nextup;
  logic                 nextdown;
  flr_vec_t             upcall;
  flr_vec_t             downcall;
  flr_vec_t             floor_btn;
  logic                 req_above;
  logic                 req_below;
  logic                 any_req;

  modport master (
    output upcall_input, downcall_input,
    output floor_btn_input, floor, status,
    output nextup, nextdown,
    input  upcall, downcall, floor_btn,
    input  req_above, req_below, any_req
  );

  modport slave (
    input  upcall_input, downcall_input,
    input  floor_btn_input, floor, status,
    input  nextup, nextdown,
    output upcall, downcall, floor_btn,
    output req_above, req_below, any_req
  );

endinterface

// File: rtl/btn_debounce.sv
// Synchronise and debounce one raw button.
// Emits a one-cycle press pulse on an accepted rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          s;
  logic          d;
  logic [CW-1:0] cnt;

  // two-flop synchroniser for the asynchronous button
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      s    <= 1'b0;
    end else begin
      meta <= raw;
      s    <= meta;
    end
  end

  // accept s only after it differs from d for the full window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d     <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (s == d) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        d     <= s;
        cnt   <= '0;
        press <= s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/request_buffer.sv
// Latch debounced button presses as pending requests and
// clear them as the car services each floor.
module request_buffer (
  input  logic             clk,
  input  logic             rst,
  request_buffer_if.slave  bus
);
  import elevator_pkg::*;

  localparam flr_vec_t UP_MASK =
    {1'b0, {(NUM_FLOORS-1){1'b1}}};
  localparam flr_vec_t DN_MASK =
    {{(NUM_FLOORS-1){1'b1}}, 1'b0};

  flr_vec_t up_press;
  flr_vec_t dn_press;
  flr_vec_t fb_press;
  flr_vec_t hit;
  flr_vec_t up_clr;
  flr_vec_t dn_clr;
  flr_vec_t pend;

  for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_up (
      .clk  (clk),
      .rst  (rst),
      .raw  (bus.upcall_input[i]),
      .press(up_press[i])
    );
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_dn (
      .clk  (clk),
      .rst  (rst),
      .raw  (bus.downcall_input[i]),
      .press(dn_press[i])
    );
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_fb (
      .clk  (clk),
      .rst  (rst),
      .raw  (bus.floor_btn_input[i]),
      .press(fb_press[i])
    );
  end

  // door open at a floor clears the calls in the travel direction
  always_comb begin
    hit    = '0;
    up_clr = '0;
    dn_clr = '0;
    if (bus.status == ST_OPEN)
      hit = floor_mask(bus.floor);
    if (bus.nextup || !bus.nextdown)
      up_clr = hit;
    if (bus.nextdown || !bus.nextup)
      dn_clr = hit;
  end

  // set on press, clear on service; clear wins on the same bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.upcall    <= '0;
      bus.downcall  <= '0;
      bus.floor_btn <= '0;
    end else begin
      bus.upcall <=
        (bus.upcall | up_press) & ~up_clr & UP_MASK;
      bus.downcall <=
        (bus.downcall | dn_press) & ~dn_clr & DN_MASK;
      bus.floor_btn <=
        (bus.floor_btn | fb_press) & ~hit;
    end
  end

  // direction hints relative to the current floor
  always_comb begin
    pend = bus.upcall | bus.downcall | bus.floor_btn;
    bus.req_above = 1'b0;
    bus.req_below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (FLOOR_W'(i) > bus.floor)
        bus.req_above = bus.req_above | pend[i];
      if (FLOOR_W'(i) < bus.floor)
        bus.req_below = bus.req_below | pend[i];
    end
    bus.any_req = |pend;
  end

endmodule

// File: tb/tb_request_buffer.sv
// Directed scoreboard bench for request_buffer.
// Expectations are queued with a due cycle; a monitor checks them.
module tb_request_buffer;
  import elevator_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  request_buffer_if bus ();

  request_buffer dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string       name;
    int          due;
    logic [26:0] exp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_out(
    input string      nm,
    input int         dly,
    input logic [7:0] up,
    input logic [7:0] dn,
    input logic [7:0] fb,
    input logic       ab,
    input logic       bl,
    input logic       an
  );
    exp_t e;
    e.name = nm;
    e.due  = cyc + dly;
    e.exp  = {up, dn, fb, ab, bl, an};
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_btns;
    bus.upcall_input    = '0;
    bus.downcall_input  = '0;
    bus.floor_btn_input = '0;
  endtask

  task automatic do_reset;
    clr_btns();
    bus.floor    = '0;
    bus.status   = ST_IDLE;
    bus.nextup   = 1'b0;
    bus.nextdown = 1'b0;
    rst = 1'b0;
    step(2);
    rst = 1'b1;
  endtask

  // monitor: compare every expectation due this cycle
  initial begin
    logic [26:0] act;
    forever begin
      @(negedge clk);
      act = {bus.upcall, bus.downcall, bus.floor_btn,
             bus.req_above, bus.req_below, bus.any_req};
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].due == cyc) begin
          checks++;
          if (act !== q[i].exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h",
                     q[i].name, act, q[i].exp);
          end
          q.delete(i);
        end
      end
    end
  end

  initial begin
    bus.floor    = '0;
    bus.status   = ST_IDLE;
    bus.nextup   = 1'b0;
    bus.nextdown = 1'b0;
    bus.upcall_input    = '1;
    bus.downcall_input  = '1;
    bus.floor_btn_input = '1;
    rst = 1'b0;

    // reset with buttons held, then one cabin press
    step(2);
    checks++;
    if ({bus.upcall, bus.downcall, bus.floor_btn,
         bus.any_req} !== 25'h0) begin
      errors++;
      $display("FAIL t1_inline_rst");
    end
    expect_out("t1_rst_a", 0, 0, 0, 0, 0, 0, 0);
    expect_out("t1_rst_b", 1, 0, 0, 0, 0, 0, 0);
    step(2);
    clr_btns();
    bus.floor_btn_input = 8'h20;
    rst = 1'b1;
    expect_out("t1_pre", 6, 0, 0, 0, 0, 0, 0);
    expect_out("t1_lat", 7, 0, 0, 8'h20, 1, 0, 1);
    step(8);
    checks++;
    if (bus.floor_btn !== 8'h20) begin
      errors++;
      $display("FAIL t1_inline_fb: %h", bus.floor_btn);
    end

    // bouncing hall button, then a steady hold
    do_reset();
    repeat (3) begin
      bus.upcall_input[2] = 1'b1;
      step(3);
      expect_out("t2_bounce", 0, 0, 0, 0, 0, 0, 0);
      bus.upcall_input[2] = 1'b0;
      step(1);
    end
    bus.upcall_input[2] = 1'b1;
    expect_out("t2_pre", 6, 0, 0, 0, 0, 0, 0);
    expect_out("t2_hold", 7, 8'h04, 0, 0, 1, 0, 1);
    step(8);

    // service floor 4 going up, then idle
    do_reset();
    bus.upcall_input[4]    = 1'b1;
    bus.downcall_input[4]  = 1'b1;
    bus.floor_btn_input[4] = 1'b1;
    expect_out("t3_set", 7, 8'h10, 8'h10, 8'h10, 1, 0, 1);
    step(7);
    clr_btns();
    step(1);
    bus.floor  = 3'd4;
    bus.status = ST_OPEN;
    bus.nextup = 1'b1;
    expect_out("t3_at4", 0, 8'h10, 8'h10, 8'h10, 0, 0, 1);
    expect_out("t3_up", 1, 0, 8'h10, 0, 0, 0, 1);
    step(1);
    bus.nextup = 1'b0;
    expect_out("t3_idle", 1, 0, 0, 0, 0, 0, 0);
    step(1);
    bus.status = ST_IDLE;
    step(1);

    // press at the open floor collides with clear
    do_reset();
    bus.floor  = 3'd2;
    bus.status = ST_OPEN;
    bus.floor_btn_input = 8'h44;
    expect_out("t4_pre", 6, 0, 0, 0, 0, 0, 0);
    expect_out("t4_set6", 7, 0, 0, 8'h40, 1, 0, 1);
    expect_out("t4_no2", 10, 0, 0, 8'h40, 1, 0, 1);
    step(8);
    checks++;
    if (bus.floor_btn !== 8'h40) begin
      errors++;
      $display("FAIL t4_inline_fb: %h", bus.floor_btn);
    end
    clr_btns();
    step(3);
    bus.status = ST_IDLE;
    step(1);

    // masked end calls and direction hints
    do_reset();
    bus.floor = 3'd3;
    bus.upcall_input    = 8'h80;
    bus.downcall_input  = 8'h01;
    bus.floor_btn_input = 8'h02;
    expect_out("t5_pre", 6, 0, 0, 0, 0, 0, 0);
    expect_out("t5_mask", 7, 0, 0, 8'h02, 0, 1, 1);
    step(8);
    do_reset();
    bus.floor = 3'd3;
    bus.downcall_input = 8'h08;
    expect_out("t5_cur", 7, 0, 8'h08, 0, 0, 0, 1);
    step(8);

    // reset mid-debounce with a request pending
    do_reset();
    bus.floor_btn_input = 8'h01;
    step(7);
    expect_out("t6_pend", 0, 0, 0, 8'h01, 0, 0, 1);
    clr_btns();
    step(1);
    bus.upcall_input = 8'h02;
    step(4);
    rst = 1'b0;
    expect_out("t6_async", 0, 0, 0, 0, 0, 0, 0);
    bus.upcall_input = '0;
    step(1);
    rst = 1'b1;
    expect_out("t6_np_a", 1, 0, 0, 0, 0, 0, 0);
    expect_out("t6_np_b", 7, 0, 0, 0, 0, 0, 0);
    expect_out("t6_np_c", 10, 0, 0, 0, 0, 0, 0);
    step(12);

    step(2);
    foreach (q[i]) begin
      errors++;
      $display("FAIL %s: never checked, due %0d",
               q[i].name, q[i].due);
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
